// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage and controller: opcodes, NOP encoding and fetch FSM states.
package fetch_unit_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [31:0] InstrNop = 32'h0000_0013;

    localparam logic [1:0] StReq  = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StFull = 2'd2;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Program counter flop with redirect mux and +4 adder; redirect always wins over advance.
module fetch_unit_pc_register
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        advance,
    output logic [31:0] pc,
    output logic [31:0] pc_next
);

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = word_align(redirect_target);
        end else if (advance) begin
            pc_next = pc + 32'd4;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= word_align(RESET_PC);
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, holds the returned word for decode,
// and drops responses that a redirect has made stale.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] fetch_count
);

    logic [1:0]  state_q, state_d;
    logic        stale_q, stale_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_pc_q;
    logic [31:0] fetch_count_q;
    logic [31:0] pc, pc_next;
    logic        capture, handshake;

    fetch_unit_pc_register #(
        .RESET_PC(RESET_PC)
    ) u_pc_register (
        .clock          (clock),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .advance        (capture),
        .pc             (pc),
        .pc_next        (pc_next)
    );

    always_comb begin
        state_d   = state_q;
        stale_d   = stale_q;
        capture   = 1'b0;
        handshake = 1'b0;
        case (state_q)
            StReq: begin
                if (redirect) stale_d = 1'b1;
                if (imem_req_ready) state_d = StWait;
            end
            StWait: begin
                if (imem_resp_valid) begin
                    if (stale_q || redirect) begin
                        stale_d = 1'b0;
                        state_d = StReq;
                    end else begin
                        capture = 1'b1;
                        state_d = StFull;
                    end
                end else if (redirect) begin
                    stale_d = 1'b1;
                end
            end
            StFull: begin
                handshake = instr_ready;
                if (instr_ready || redirect) state_d = StReq;
            end
            default: state_d = StReq;
        endcase
    end

    // The presented address is frozen while a request is pending, even if pc is redirected.
    assign addr_d = (state_q == StReq && state_d == StReq) ? addr_q : pc_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StReq;
            stale_q       <= 1'b0;
            addr_q        <= word_align(RESET_PC);
            instr_q       <= InstrNop;
            instr_pc_q    <= word_align(RESET_PC);
            fetch_count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            stale_q <= stale_d;
            addr_q  <= addr_d;
            if (capture) begin
                instr_q    <= imem_resp_data;
                instr_pc_q <= pc;
            end
            if (handshake) fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign imem_req_valid = (state_q == StReq) && !reset;
    assign imem_addr      = addr_q;
    assign instr_valid    = (state_q == StFull);
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_pc_plus4 = instr_pc_q + 32'd4;
    assign opcode         = instr_q[6:0];
    assign funct3         = instr_q[14:12];
    assign funct7b5       = instr_q[30];
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural memory, scoreboard of accepted fetch addresses,
// a vector table for sequential fetches, and directed redirect/wrap/reset sequences.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] fetch_count;

    fetch_unit #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .opcode         (opcode),
        .funct3         (funct3),
        .funct7b5       (funct7b5),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .fetch_count    (fetch_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         lat;
        int         dec_wait;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       f7b5;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [16];
    logic [31:0] exp_q[$];
    logic        skip_accept = 1'b0;
    logic        mem_ready = 1'b1;
    int          lat = 1;
    int          resp_cnt = 0;
    logic [31:0] resp_addr = 32'd0;
    logic [31:0] last_acc_addr = 32'd0;
    vec_t        vecs [6];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem[a[5:2]];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive memory, scoreboard the decode handshake, then track acceptances.
    task automatic cycle();
        logic        acc, hs, in_req;
        logic [31:0] a, e;
        imem_req_ready  = mem_ready;
        imem_resp_valid = (resp_cnt == 1);
        imem_resp_data  = mem_word(resp_addr);
        acc    = imem_req_valid && imem_req_ready;
        a      = imem_addr;
        in_req = imem_req_valid;
        hs     = instr_valid && instr_ready;
        if (hs) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr_pc", instr_pc, e);
                chk("sb_instr", instr, mem_word(e));
                chk("sb_pc_plus4", instr_pc_plus4, e + 32'd4);
            end
        end
        @(posedge clock);
        #1;
        if (resp_cnt > 0) resp_cnt--;
        if (acc) begin
            resp_cnt      = lat;
            resp_addr     = a;
            last_acc_addr = a;
            if (skip_accept) skip_accept = 1'b0;
            else exp_q.push_back(a);
        end
        if (redirect) begin
            exp_q.delete();
            if (in_req && !acc) skip_accept = 1'b1;
        end
        if (reset) begin
            exp_q.delete();
            skip_accept = 1'b0;
        end
        redirect        = 1'b0;
        imem_resp_valid = 1'b0;
    endtask

    task automatic run_until_valid();
        for (int i = 0; i < 20 && !instr_valid; i++) cycle();
        chk("wait_valid", 32'(instr_valid), 32'd1);
    endtask

    task automatic accept_decode();
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved, c;
        logic        leaked;

        mem[0]  = 32'h0000_0003;
        mem[1]  = 32'h0000_2083;
        mem[2]  = 32'h4020_81b3;
        mem[3]  = 32'h0020_a023;
        mem[4]  = 32'h0000_0463;
        mem[5]  = 32'h0050_7093;
        mem[6]  = 32'h0080_00ef;
        mem[7]  = 32'h4030_d233;
        for (int i = 8; i < 15; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
        mem[15] = 32'h0ff0_0093;

        vecs[0] = '{lat: 1, dec_wait: 0, opc: 7'b0110011, f3: 3'b000, f7b5: 1'b1};
        vecs[1] = '{lat: 2, dec_wait: 1, opc: 7'b0100011, f3: 3'b010, f7b5: 1'b0};
        vecs[2] = '{lat: 3, dec_wait: 0, opc: 7'b1100011, f3: 3'b000, f7b5: 1'b0};
        vecs[3] = '{lat: 1, dec_wait: 2, opc: 7'b0010011, f3: 3'b111, f7b5: 1'b0};
        vecs[4] = '{lat: 2, dec_wait: 0, opc: 7'b1101111, f3: 3'b000, f7b5: 1'b0};
        vecs[5] = '{lat: 1, dec_wait: 1, opc: 7'b0110011, f3: 3'b101, f7b5: 1'b1};

        reset           = 1'b1;
        instr_ready     = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'd0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        repeat (3) cycle();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_fetch_count", fetch_count, 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_instr_pc", instr_pc, 32'd0);

        // First fetch: accept, respond next cycle, valid two cycles after acceptance.
        reset = 1'b0;
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        cycle();
        chk("first_not_yet_valid", 32'(instr_valid), 32'd0);
        cycle();
        chk("first_valid", 32'(instr_valid), 32'd1);
        chk("first_opcode", 32'(opcode), 32'b0000011);
        accept_decode();
        chk("second_req_valid", 32'(imem_req_valid), 32'd1);
        chk("second_addr", imem_addr, 32'd4);
        chk("count_after_first", fetch_count, 32'd1);

        // Backpressure: hold decode off for 5 cycles in FULL.
        cycle();
        cycle();
        chk("bp_valid", 32'(instr_valid), 32'd1);
        saved = instr;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_instr_stable", instr, saved);
            chk("bp_instr_pc", instr_pc, 32'd4);
            chk("bp_no_req", 32'(imem_req_valid), 32'd0);
            chk("bp_count", fetch_count, 32'd1);
        end
        accept_decode();
        chk("bp_count_release", fetch_count, 32'd2);

        // Sequential fetches from 8 with varied latency and decode stalls.
        for (int i = 0; i < 6; i++) begin
            lat = vecs[i].lat;
            run_until_valid();
            chk("vec_instr_pc", instr_pc, 32'(8 + 4 * i));
            chk("vec_opcode", 32'(opcode), 32'(vecs[i].opc));
            chk("vec_funct3", 32'(funct3), 32'(vecs[i].f3));
            chk("vec_funct7b5", 32'(funct7b5), 32'(vecs[i].f7b5));
            repeat (vecs[i].dec_wait) cycle();
            accept_decode();
        end
        chk("vec_count", fetch_count, 32'd8);

        // Redirect while waiting on the response for address 32.
        lat = 2;
        chk("rw_addr", imem_addr, 32'd32);
        cycle();
        redirect        = 1'b1;
        redirect_target = 32'h0000_0102;
        cycle();
        leaked = 1'b0;
        for (int i = 0; i < 10 && !imem_req_valid; i++) begin
            cycle();
            if (instr_valid) leaked = 1'b1;
        end
        chk("rw_no_leak", 32'(leaked), 32'd0);
        chk("rw_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rw_next_addr", imem_addr, 32'h0000_0100);
        lat = 1;
        run_until_valid();
        chk("rw_instr_pc", instr_pc, 32'h0000_0100);
        accept_decode();

        // Redirect in REQ while memory is not ready: old address holds, response dropped.
        mem_ready       = 1'b0;
        redirect        = 1'b1;
        redirect_target = 32'h0000_0023;
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("rr_req_valid", 32'(imem_req_valid), 32'd1);
            chk("rr_addr_hold", imem_addr, 32'h0000_0104);
            if (i < 2) cycle();
        end
        mem_ready = 1'b1;
        cycle();
        chk("rr_old_accepted", last_acc_addr, 32'h0000_0104);
        run_until_valid();
        chk("rr_next_accept", last_acc_addr, 32'h0000_0020);
        chk("rr_instr_pc", instr_pc, 32'h0000_0020);

        // Redirect in FULL together with a decode handshake.
        c               = fetch_count;
        redirect        = 1'b1;
        redirect_target = 32'h0000_0040;
        instr_ready     = 1'b1;
        cycle();
        instr_ready = 1'b0;
        chk("rf_count", fetch_count, c + 32'd1);
        chk("rf_valid_low", 32'(instr_valid), 32'd0);
        chk("rf_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rf_addr", imem_addr, 32'h0000_0040);

        // PC wrap from the top word.
        mem_ready       = 1'b0;
        redirect        = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        cycle();
        mem_ready = 1'b1;
        run_until_valid();
        chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", instr_pc_plus4, 32'd0);
        accept_decode();
        chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
        chk("wrap_addr", imem_addr, 32'd0);

        // Reset while a slow response is outstanding; the late response must be ignored.
        lat = 3;
        cycle();
        chk("mr_waiting", 32'(instr_valid), 32'd0);
        reset = 1'b1;
        cycle();
        chk("mr_instr_valid", 32'(instr_valid), 32'd0);
        chk("mr_fetch_count", fetch_count, 32'd0);
        chk("mr_instr", instr, 32'h0000_0013);
        chk("mr_instr_pc", instr_pc, 32'd0);
        chk("mr_req_valid", 32'(imem_req_valid), 32'd0);
        reset     = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("mr_late_ignored", 32'(instr_valid), 32'd0);
            chk("mr_req_addr", imem_addr, 32'd0);
        end
        chk("mr_req_pending", 32'(imem_req_valid), 32'd1);
        mem_ready = 1'b1;
        lat       = 1;
        run_until_valid();
        chk("mr_refetch_pc", instr_pc, 32'd0);
        chk("mr_refetch_instr", instr, 32'h0000_0003);
        accept_decode();
        chk("mr_count", fetch_count, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RISC-V CPU, sitting directly upstream of `controller`. Holds the program counter and issues one instruction-memory request at a time over a valid/ready handshake. Holds each returned word until the decode stage accepts it, and splits out `opcode`, `funct3` and `funct7b5` for the controller. A redirect input from execute replaces the PC on taken branches and jumps, and discards any in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `imem_req_valid`  out  1: fetch request valid.
- `imem_req_ready`  in  1: memory accepts request.
- `imem_addr`  out  32: word-aligned fetch address.
- `imem_resp_valid`  in  1: response word valid, single-cycle pulse.
- `imem_resp_data`  in  32: instruction word.
- `instr_valid`  out  1: held instruction valid.
- `instr_ready`  in  1: decode accepts instruction.
- `instr`  out  32: held instruction.
- `instr_pc`  out  32: address of `instr`.
- `instr_pc_plus4`  out  32: `instr_pc + 4`, used for the jal link.
- `opcode`  out  7: `instr[6:0]`.
- `funct3`  out  3: `instr[14:12]`.
- `funct7b5`  out  1: `instr[30]`.
- `redirect`  in  1: taken branch or jump.
- `redirect_target`  in  32: new PC; bits [1:0] are forced to 0.
- `fetch_count`  out  32: count of instructions handed to decode.

## Operation
- States:
  - REQ: `imem_req_valid`=1, `imem_addr`=pc.
  - WAIT: one request outstanding.
  - FULL: `instr_valid`=1.
- Only one request is ever outstanding.
- Address stability: once `imem_req_valid` is high, `imem_addr` holds until `imem_req_ready`, even across a redirect.
- Transitions:
  - REQ to WAIT when `imem_req_ready`.
  - WAIT with `imem_resp_valid` and `stale`=0: capture data into `instr`, pc into `instr_pc`, then pc <= pc+4 and go to FULL.
  - WAIT with `imem_resp_valid` and `stale`=1: drop the data, clear `stale`, go to REQ.
  - FULL with `instr_ready` (handshake): increment `fetch_count` (wraps at 2^32), go to REQ.
- Redirect, checked every cycle and taking priority over pc+4:
  - pc <= `redirect_target & ~3`.
  - In REQ: set `stale`. The request still completes and its response is dropped.
  - In WAIT: set `stale`. If `imem_resp_valid` arrives in the same cycle, drop the data and go to REQ.
  - In FULL: discard the held instruction (`instr_valid` low next cycle) and go to REQ. If `instr_ready` is also high, the handshake counts and `fetch_count` increments.
- Stale rule: a `stale` flag set in REQ carries into WAIT.
- Response protocol: `imem_resp_valid` outside WAIT is a protocol error and is ignored.
- Width rule: pc arithmetic is modulo 2^32. pc = 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values:
  - state = REQ, pc = `RESET_PC`, `stale` = 0, `fetch_count` = 0.
  - `instr` = 32'h0000_0013 (NOP), `instr_pc` = `RESET_PC`, `instr_valid` = 0.
- While `reset` is high, `imem_req_valid` is forced to 0. It is 1 in the first cycle after reset deasserts.
- Reset mid-operation discards any outstanding request. Responses arriving after reset are ignored until the next WAIT.
- Memory: a response arrives no earlier than the cycle after acceptance.
- Best-case latency: acceptance in cycle N, response in N+1, `instr_valid` high in N+2.
- Throughput: at most one instruction per 3 cycles.
- All outputs are registered or decoded from state. There is no combinational path from `instr_ready` or `redirect` to any output.

## Structure
- Shared header `cpu_defines.vh` holds:
  - opcode constants (lw, sw, R-type, beq, I-type ALU, jal);
  - the NOP encoding;
  - the fetch state encodings.
- `controller` uses the same opcode constants.
- Optional sub-module: `pc_register`, holding the pc flop, redirect mux and +4 adder.
- The FSM, `stale` flag and instruction register stay in `fetch_unit`.

## Test plan
- Reset and first fetch:
  - Stimulus: `RESET_PC`=0, memory always ready, 1-cycle latency, word 32'h00000003 (lw).
  - Response: `imem_addr`=0, `instr_valid` two cycles after acceptance, `opcode`=7'b0000011, next request at 4.
- Backpressure:
  - Stimulus: hold `instr_ready`=0 for 5 cycles in FULL.
  - Response: `instr`/`instr_pc` stable, no new request, `fetch_count` unchanged. After release it increments by 1.
- Redirect in WAIT:
  - Stimulus: redirect to 32'h0000_0102 while fetching address 8.
  - Response: word from 8 never reaches `instr_valid`, next `imem_addr`=32'h0000_0100.
- Redirect in REQ with `imem_req_ready`=0:
  - Response: `imem_addr` holds the old pc until accepted, the response is dropped, the next request uses the target.
- Redirect in FULL together with `instr_ready`:
  - Response: `fetch_count` increments, `instr_valid` low the next cycle, fetch from the target.
- Wrap and mid-operation reset:
  - Stimulus: pc = 32'hFFFF_FFFC.
  - Response: the next fetch is at 0.
  - Stimulus: assert reset in WAIT.
  - Response: all reset values restored, and a late `imem_resp_valid` is ignored.
